// File: rtl/counter_nbit_updown_mod.sv
// counter_nbit_updown_mod
// WIDTH-bit, modulo-MODULUS up/down counter with count enable, direction,
// synchronous parallel load, a combinational terminal-count flag and
// registered one-cycle wrap / load-error pulses.
// Optional build macro: COUNTER_SATURATE_EN -- when defined the counter pins
// at its bounds instead of wrapping (wrap never asserts); load is unchanged.
// Clock is 'count', asynchronous active-high reset is 'clear'.

module counter_nbit_updown_mod #(
  parameter int WIDTH     = 4,   // counter width, >= 1
  parameter int MODULUS   = 16,  // 2 <= MODULUS <= 2**WIDTH
  parameter int RESET_VAL = 0    // < MODULUS
) (
  input  logic             count,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Bounds held one bit wider than the counter so MODULUS = 2**WIDTH is
  // representable and the increment never overflows before the compare.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_d_ok;

  logic [WIDTH-1:0] w_out_next;
  logic             w_wrap_next;
  logic             w_err_next;

  // Widened increment: reaching LP_MOD means the current value is the top.
  assign w_inc    = {1'b0, r_out} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec    = r_out - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_at_max = (w_inc == LP_MOD);
  assign w_at_min = (r_out == '0);
  assign w_d_ok   = ({1'b0, d} < LP_MOD);

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    w_out_next  = r_out;
    w_wrap_next = 1'b0;
    w_err_next  = 1'b0;
    if (load) begin
      if (w_d_ok) begin
        w_out_next = d;
      end else begin
        // Out-of-range load clamps to the top of the range and flags it.
        w_out_next = LP_TOP;
        w_err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
`ifdef COUNTER_SATURATE_EN
          w_out_next = LP_TOP;
`else
          w_out_next  = '0;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_out_next = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_at_min) begin
`ifdef COUNTER_SATURATE_EN
          w_out_next = '0;
`else
          w_out_next  = LP_TOP;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_out_next = w_dec;
        end
      end
    end
  end

  // State register; clear acts immediately and dominates everything.
  always_ff @(posedge count or posedge clear) begin
    if (clear) begin
      r_out      <= LP_RST;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_out      <= w_out_next;
      r_wrap     <= w_wrap_next;
      r_load_err <= w_err_next;
    end
  end

  // Terminal count follows inputs and count without delay for cascading.
  assign tc       = en & ~load & (up ? w_at_max : w_at_min);
  assign out      = r_out;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_counter_nbit_updown_mod.sv
// Bench for counter_nbit_updown_mod: a modulo-10 instance and a modulo-16
// instance share all inputs; table vectors plus hand-written corner cases.
`timescale 1ns/1ps

module tb_counter_nbit_updown_mod;

  logic       count = 1'b0;
  logic       clear = 1'b1;
  logic       en    = 1'b0;
  logic       up    = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] d     = 4'd0;

  logic [3:0] out10, out16;
  logic       tc10, tc16, wrap10, wrap16, err10, err16;

  counter_nbit_updown_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_m10 (
    .count(count), .clear(clear), .en(en), .up(up), .load(load), .d(d),
    .out(out10), .tc(tc10), .wrap(wrap10), .load_err(err10));

  counter_nbit_updown_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_m16 (
    .count(count), .clear(clear), .en(en), .up(up), .load(load), .d(d),
    .out(out16), .tc(tc16), .wrap(wrap16), .load_err(err16));

  always #5 count = ~count;

  typedef struct {
    int ld; int en; int up; int d;
    int tc; int out; int wrap; int err;
  } vec_t;

  typedef struct {
    int sel; int out; int wrap; int err; int id;
  } exp_t;

  vec_t vecs[64];
  int   n_vec = 0;
  exp_t sb_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s#%0d: got %0d expected %0d", name, id, act, exp);
  endtask

  task automatic add_vec(input int ld_, input int en_, input int up_, input int d_,
                         input int tc_, input int out_, input int wrap_, input int err_);
    vecs[n_vec] = '{ld_, en_, up_, d_, tc_, out_, wrap_, err_};
    n_vec++;
  endtask

  function automatic int get_out(input int sel);
    return (sel == 0) ? int'(out10) : int'(out16);
  endfunction
  function automatic int get_tc(input int sel);
    return (sel == 0) ? int'(tc10) : int'(tc16);
  endfunction
  function automatic int get_wrap(input int sel);
    return (sel == 0) ? int'(wrap10) : int'(wrap16);
  endfunction
  function automatic int get_err(input int sel);
    return (sel == 0) ? int'(err10) : int'(err16);
  endfunction

  // Called one time unit after a rising edge: drive, check tc, queue the
  // expected registered result, clock once, then pop and compare.
  task automatic step(input int sel, input int ld_, input int en_, input int up_, input int d_,
                      input int tc_, input int out_, input int wrap_, input int err_, input int id);
    exp_t e;
    load = ld_[0]; en = en_[0]; up = up_[0]; d = d_[3:0];
    #1;
    chk("tc", id, get_tc(sel), tc_);
    sb_q.push_back('{sel, out_, wrap_, err_, id});
    @(posedge count); #1;
    e = sb_q.pop_front();
    chk("out", e.id, get_out(e.sel), e.out);
    chk("wrap", e.id, get_wrap(e.sel), e.wrap);
    chk("load_err", e.id, get_err(e.sel), e.err);
    $display("vec %0d sel=%0d ld=%0d en=%0d up=%0d d=%0d -> out=%0d tc=%0d wrap=%0d err=%0d",
             id, sel, ld_, en_, up_, d_, get_out(sel), tc_, get_wrap(sel), get_err(sel));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table for the modulo-10 instance, starting from out=0.
`ifdef COUNTER_SATURATE_EN
    add_vec(1, 0, 1, 8,  0, 8, 0, 0);
    add_vec(0, 1, 1, 0,  0, 9, 0, 0);
    add_vec(0, 1, 1, 0,  1, 9, 0, 0);
    add_vec(0, 1, 1, 0,  1, 9, 0, 0);
    add_vec(1, 0, 0, 1,  0, 1, 0, 0);
    add_vec(0, 1, 0, 0,  0, 0, 0, 0);
    add_vec(0, 1, 0, 0,  1, 0, 0, 0);
    add_vec(0, 1, 0, 0,  1, 0, 0, 0);
`else
    for (int k = 0; k < 11; k++)
      add_vec(0, 1, 1, 0, (k % 10 == 9) ? 1 : 0, (k + 1) % 10, (k % 10 == 9) ? 1 : 0, 0);
    add_vec(1, 1, 1, 3,  0, 3, 0, 0);
    add_vec(0, 1, 0, 0,  0, 2, 0, 0);
    add_vec(0, 1, 0, 0,  0, 1, 0, 0);
    add_vec(0, 1, 0, 0,  0, 0, 0, 0);
    add_vec(0, 1, 0, 0,  1, 9, 1, 0);
    add_vec(0, 1, 0, 0,  0, 8, 0, 0);
`endif
    add_vec(1, 0, 0, 12, 0, 9, 0, 1);
    add_vec(0, 0, 0, 0,  0, 9, 0, 0);
    add_vec(1, 0, 1, 5,  0, 5, 0, 0);
    add_vec(1, 1, 1, 10, 0, 9, 0, 1);
    add_vec(0, 0, 1, 0,  0, 9, 0, 0);

    // Reset state while clear is held.
    #1;
    chk("rst_out10", 0, out10, 0);
    chk("rst_wrap10", 0, wrap10, 0);
    chk("rst_err10", 0, err10, 0);
    chk("rst_out16", 0, out16, 0);
    @(posedge count); #1;
    chk("rst_hold", 0, out10, 0);
    clear = 1'b0;

    for (int i = 0; i < n_vec; i++)
      step(0, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].d,
           vecs[i].tc, vecs[i].out, vecs[i].wrap, vecs[i].err, i);

    // Asynchronous clear mid-cycle while counting at 7.
    step(0, 1, 0, 1, 7, 0, 7, 0, 0, 100);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk("c4_tc", 101, tc10, 0);
    #2;
    clear = 1'b1;
    #1;
    chk("c4_async_out", 102, out10, 0);
    chk("c4_async_wrap", 102, wrap10, 0);
    $display("clear asserted mid-cycle -> out=%0d", out10);
    for (int j = 0; j < 2; j++) begin
      @(posedge count); #1;
      chk("c4_held", 103 + j, out10, 0);
      $display("clear held edge %0d -> out=%0d", j, out10);
    end
    #3;
    clear = 1'b0;
    @(posedge count); #1;
    chk("c4_release", 105, out10, 1);
    $display("clear released -> out=%0d", out10);

    // Full-range modulus 16 instance.
    step(1, 1, 0, 1, 15, 0, 15, 0, 0, 200);
`ifdef COUNTER_SATURATE_EN
    step(1, 0, 1, 1, 0,  1, 15, 0, 0, 201);
    step(1, 1, 0, 0, 0,  0, 0,  0, 0, 202);
    step(1, 0, 1, 0, 0,  1, 0,  0, 0, 203);
`else
    step(1, 0, 1, 1, 0,  1, 0,  1, 0, 201);
    step(1, 0, 1, 0, 0,  1, 15, 1, 0, 202);
    step(1, 0, 1, 0, 0,  0, 14, 0, 0, 203);
`endif
    step(1, 1, 1, 1, 4,  0, 4,  0, 0, 204);
    step(1, 0, 0, 1, 0,  0, 4,  0, 0, 205);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
